// File: rtl/tff_updown_counter_pkg.sv
// +--------------------------------------------------------------------------+
// | tff_counter_defs : shared terminal-count constants and direction encoding |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package tff_counter_defs;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  localparam longint unsigned TERM_DN = 64'd0;

  // Up-count terminal value depends on the modulus, so it is a function.
  function automatic longint unsigned term_up(input longint unsigned mod);
    return mod - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tff_updown_counter_if.sv
// +--------------------------------------------------------------------------+
// | tff_updown_counter_if : control, load and status bundle of the counter   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tff_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             E;
  logic             UP;
  logic             L;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;

  modport master (output E, UP, L, D, input Q, TC);
  modport slave  (input E, UP, L, D, output Q, TC);
endinterface

`default_nettype wire

// File: rtl/tff_updown_counter_cell.sv
// +--------------------------------------------------------------------------+
// | tff_cell : one toggle flip-flop bit, Q <= Q ^ T, sync reset to INIT      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tff_cell #(
  parameter logic INIT = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_t,
  output logic      o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= INIT;
    else     r_q <= r_q ^ i_t;
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/tff_updown_counter.sv
// +--------------------------------------------------------------------------+
// | tff_updown_counter : up/down modulo counter built from toggle bit cells  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tff_updown_counter
  import tff_counter_defs::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MOD     = 64'd1 << WIDTH,
  parameter longint unsigned RST_VAL = 64'd0
) (
  input  wire logic             C,
  input  wire logic             R,
  tff_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] c_term_up = WIDTH'(term_up(MOD));
  localparam logic [WIDTH-1:0] c_term_dn = WIDTH'(TERM_DN);
  localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

  if (MOD < 64'd2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("tff_updown_counter: MOD out of range 2..2**WIDTH");
  end
  if (RST_VAL >= MOD) begin : g_bad_rst
    $error("tff_updown_counter: RST_VAL must be below MOD");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_t_up;
  logic [WIDTH-1:0] w_t_dn;
  logic             w_at_top;
  logic             w_at_zero;

  // Plain-count toggles: bit i flips when all lower bits are 1 (up) or 0 (down).
  for (genvar i = 0; i < WIDTH; i++) begin : g_toggle
    localparam logic [WIDTH-1:0] c_low_mask = WIDTH'((64'd1 << i) - 64'd1);
    assign w_t_up[i] = ((w_q & c_low_mask) == c_low_mask);
    assign w_t_dn[i] = ((w_q & c_low_mask) == '0);
  end

  assign w_at_top  = (w_q == c_term_up);
  assign w_at_zero = (w_q == c_term_dn);

  // Load and modulo wrap are expressed as toggle masks Q ^ target.
  always_comb begin
    w_t = '0;
    if (bus.L) begin
      w_t = w_q ^ bus.D;
    end else if (bus.E) begin
      if (dir_e'(bus.UP) == DIR_UP) w_t = w_at_top  ? w_q               : w_t_up;
      else                          w_t = w_at_zero ? (w_q ^ c_term_up) : w_t_dn;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell #(
      .INIT (c_rst_val[i])
    ) u_cell (
      .clk (C),
      .rst (R),
      .i_t (w_t[i]),
      .o_q (w_q[i])
    );
  end

  assign bus.Q  = w_q;
  assign bus.TC = bus.E & ~bus.L & (bus.UP ? w_at_top : w_at_zero);

endmodule

`default_nettype wire

// File: tb/tb_tff_updown_counter.sv
// +--------------------------------------------------------------------------+
// | tb_tff_updown_counter : directed vectors, odd-parameter and cascade runs |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tff_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r_main = 1'b0;
  logic r_odd  = 1'b0;
  logic r_cas  = 1'b0;

  tff_updown_counter_if #(.WIDTH(4)) m_if ();
  tff_updown_counter_if #(.WIDTH(3)) o_if ();
  tff_updown_counter_if #(.WIDTH(4)) lo_if ();
  tff_updown_counter_if #(.WIDTH(4)) hi_if ();

  tff_updown_counter #(.WIDTH(4), .MOD(10), .RST_VAL(0)) u_main (
    .C (clk), .R (r_main), .bus (m_if.slave)
  );
  tff_updown_counter #(.WIDTH(3), .MOD(5), .RST_VAL(3)) u_odd (
    .C (clk), .R (r_odd), .bus (o_if.slave)
  );
  tff_updown_counter #(.WIDTH(4), .MOD(16), .RST_VAL(0)) u_lo (
    .C (clk), .R (r_cas), .bus (lo_if.slave)
  );
  tff_updown_counter #(.WIDTH(4), .MOD(16), .RST_VAL(0)) u_hi (
    .C (clk), .R (r_cas), .bus (hi_if.slave)
  );

  assign hi_if.E = lo_if.TC;

  typedef struct {
    logic       r;
    logic       l;
    logic       e;
    logic       up;
    logic [3:0] d;
    logic       tc;   // TC expected before the edge
    logic [3:0] q;    // Q expected after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic void add(input logic r, input logic l, input logic e,
                              input logic up, input logic [3:0] d,
                              input logic tc, input logic [3:0] q);
    vec_t v;
    v.r = r; v.l = l; v.e = e; v.up = up; v.d = d; v.tc = tc; v.q = q;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_main(input vec_t v, input int idx);
    @(negedge clk);
    r_main = v.r; m_if.L = v.l; m_if.E = v.e; m_if.UP = v.up; m_if.D = v.d;
    #1;
    chk($sformatf("vec%0d_tc", idx), 32'(m_if.TC), 32'(v.tc));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_q", idx), 32'(m_if.Q), 32'(v.q));
  endtask

  task automatic step_odd(input string name, input logic e, input logic up,
                          input logic tc, input logic [2:0] q);
    @(negedge clk);
    o_if.E = e; o_if.UP = up;
    #1;
    chk({name, "_tc"}, 32'(o_if.TC), 32'(tc));
    @(posedge clk);
    #1;
    chk({name, "_q"}, 32'(o_if.Q), 32'(q));
  endtask

  initial begin
    m_if.E = 1'b0; m_if.UP = 1'b1; m_if.L = 1'b0; m_if.D = '0;
    o_if.E = 1'b0; o_if.UP = 1'b1; o_if.L = 1'b0; o_if.D = '0;
    lo_if.E = 1'b0; lo_if.UP = 1'b1; lo_if.L = 1'b0; lo_if.D = '0;
    hi_if.UP = 1'b1; hi_if.L = 1'b0; hi_if.D = '0;

    // Reset, then 12 up counts through the mod-10 wrap
    add(1, 0, 0, 1, 4'd0, 1'b0, 4'd0);
    for (int k = 0; k < 12; k++)
      add(0, 0, 1, 1, 4'd0, 1'((k % 10) == 9), 4'((k + 1) % 10));
    // Down-count wrap from 0
    add(0, 1, 0, 0, 4'd0, 1'b0, 4'd0);
    add(0, 0, 1, 0, 4'd0, 1'b1, 4'd9);
    add(0, 0, 1, 0, 4'd0, 1'b0, 4'd8);
    add(0, 0, 1, 0, 4'd0, 1'b0, 4'd7);
    // Priority R > L > E
    add(1, 1, 1, 1, 4'd5, 1'b0, 4'd0);
    add(0, 1, 1, 1, 4'd6, 1'b0, 4'd6);
    // Hold, then direction flip
    add(0, 1, 0, 1, 4'd5, 1'b0, 4'd5);
    add(0, 0, 0, 1, 4'd0, 1'b0, 4'd5);
    add(0, 0, 0, 1, 4'd0, 1'b0, 4'd5);
    add(0, 0, 0, 1, 4'd0, 1'b0, 4'd5);
    add(0, 0, 1, 1, 4'd0, 1'b0, 4'd6);
    add(0, 0, 1, 0, 4'd0, 1'b0, 4'd5);
    add(0, 0, 1, 1, 4'd0, 1'b0, 4'd6);
    add(0, 0, 1, 0, 4'd0, 1'b0, 4'd5);
    // Out-of-range load: binary count to 15 then wrap, TC never set
    add(0, 1, 0, 1, 4'd13, 1'b0, 4'd13);
    add(0, 0, 1, 1, 4'd0, 1'b0, 4'd14);
    add(0, 0, 1, 1, 4'd0, 1'b0, 4'd15);
    add(0, 0, 1, 1, 4'd0, 1'b0, 4'd0);
    add(0, 0, 1, 1, 4'd0, 1'b0, 4'd1);
    // Load masks TC at the terminal value; E=0 masks TC at zero
    add(0, 1, 0, 1, 4'd9, 1'b0, 4'd9);
    add(0, 1, 1, 1, 4'd3, 1'b0, 4'd3);
    add(0, 1, 0, 0, 4'd0, 1'b0, 4'd0);
    add(0, 0, 0, 0, 4'd0, 1'b0, 4'd0);
    // Reset mid-count discards a pending wrap
    add(0, 1, 0, 1, 4'd9, 1'b0, 4'd9);
    add(1, 0, 1, 1, 4'd0, 1'b1, 4'd0);

    foreach (vecs[i]) apply_main(vecs[i], i);

    // Non-zero reset value with modulus 5
    @(negedge clk);
    r_odd = 1'b1;
    @(posedge clk);
    #1;
    chk("odd_rst_q", 32'(o_if.Q), 32'd3);
    chk("odd_rst_tc", 32'(o_if.TC), 32'd0);
    @(negedge clk);
    r_odd = 1'b0;
    step_odd("odd_up1", 1'b1, 1'b1, 1'b0, 3'd4);
    step_odd("odd_up2", 1'b1, 1'b1, 1'b1, 3'd0);
    step_odd("odd_dn1", 1'b1, 1'b0, 1'b1, 3'd4);
    step_odd("odd_dn2", 1'b1, 1'b0, 1'b0, 3'd3);

    // Two-stage cascade must track the cycle count mod 256
    @(negedge clk);
    r_cas = 1'b1;
    @(posedge clk);
    #1;
    chk("cas_rst", 32'({hi_if.Q, lo_if.Q}), 32'd0);
    @(negedge clk);
    r_cas = 1'b0;
    lo_if.E = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cas_cyc%0d", n), 32'({hi_if.Q, lo_if.Q}), 32'(n % 256));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
